// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory-access stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WAIT_CNT_W = 8;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_res;
        logic [31:0] rd_data;
        logic [4:0]  wb_path;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/memwb_reg.sv
// rtl/memwb_reg.sv - MEM/WB pipeline register with bubble insertion
module memwb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   bubble_i,
    input  memwb_t d_i,
    output memwb_t q_o
);

    memwb_t q_q;

    // A bubble clears every field so WB never sees a stalled instruction twice.
    always_ff @(posedge clk_i) begin
        if (rst_i || bubble_i) begin
            q_q <= MEMWB_BUBBLE;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with req/ack data memory and timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [31:0] ALUres_i,
    input  logic [31:0] wrdata_i,
    input  logic [4:0]  WriteBackPath_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUres_o,
    output logic [31:0] rddata_o,
    output logic [4:0]  WriteBackPath_o
);

    // Counter value seen in the final WAIT cycle; req is then high MAX_WAIT cycles.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    state_t                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic [4:0]  wb_path_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        access;
    logic        stall;
    logic        latch_en;
    logic        cap_en;
    logic        timeout;
    logic [31:0] cap_data;
    memwb_t      memwb_d;
    memwb_t      memwb_q;

    assign access   = MemRead_i | MemWrite_i;
    // Stores (including read+write collisions) never return data.
    assign cap_data = (dmem_ack_i && !we_q) ? dmem_rdata_i : 32'd0;

    // State and wait-counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, stall and MEM/WB input selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        latch_en = 1'b0;
        cap_en   = 1'b0;
        timeout  = 1'b0;
        memwb_d  = MEMWB_BUBBLE;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall    = 1'b1;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end else begin
                    memwb_d.reg_write  = RegWrite_i;
                    memwb_d.mem_to_reg = MemtoReg_i;
                    memwb_d.alu_res    = ALUres_i;
                    memwb_d.rd_data    = 32'd0;
                    memwb_d.wb_path    = WriteBackPath_i;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (dmem_ack_i) begin
                    cap_en  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    cap_en  = 1'b1;
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                memwb_d.reg_write  = reg_write_q;
                memwb_d.mem_to_reg = mem_to_reg_q;
                memwb_d.alu_res    = addr_q;
                memwb_d.rd_data    = rdata_q;
                memwb_d.wb_path    = wb_path_q;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access latches, captured load data and the sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            wb_path_q    <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (latch_en) begin
                addr_q       <= ALUres_i;
                wdata_q      <= wrdata_i;
                we_q         <= MemWrite_i;
                reg_write_q  <= RegWrite_i;
                mem_to_reg_q <= MemtoReg_i;
                wb_path_q    <= WriteBackPath_i;
            end
            if (cap_en) begin
                rdata_q <= cap_data;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    memwb_reg u_memwb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bubble_i (stall),
        .d_i      (memwb_d),
        .q_o      (memwb_q)
    );

    assign dmem_req_o      = (state_q == ST_WAIT);
    assign dmem_we_o       = we_q;
    assign dmem_addr_o     = addr_q;
    assign dmem_wdata_o    = wdata_q;
    assign stall_o         = stall;
    assign err_o           = err_q;
    assign RegWrite_o      = memwb_q.reg_write;
    assign MemtoReg_o      = memwb_q.mem_to_reg;
    assign ALUres_o        = memwb_q.alu_res;
    assign rddata_o        = memwb_q.rd_data;
    assign WriteBackPath_o = memwb_q.wb_path;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a transaction-level model
module tb_mem_stage;

    localparam int M = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, mem_to_reg = 1'b0;
    logic [31:0] alu_res = '0, wr_data = '0;
    logic [4:0]  wb_path = '0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        req, we, stall, err;
    logic [31:0] addr, wdata;
    logic        rw_o, m2r_o;
    logic [31:0] alu_o, rd_o;
    logic [4:0]  wbp_o;

    int checks = 0;
    int errors = 0;
    logic err_model = 1'b0;

    mem_stage #(.MAX_WAIT(M)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .MemRead_i       (mem_read),
        .MemWrite_i      (mem_write),
        .RegWrite_i      (reg_write),
        .MemtoReg_i      (mem_to_reg),
        .ALUres_i        (alu_res),
        .wrdata_i        (wr_data),
        .WriteBackPath_i (wb_path),
        .dmem_req_o      (req),
        .dmem_we_o       (we),
        .dmem_addr_o     (addr),
        .dmem_wdata_o    (wdata),
        .dmem_ack_i      (ack),
        .dmem_rdata_i    (rdata),
        .stall_o         (stall),
        .err_o           (err),
        .RegWrite_o      (rw_o),
        .MemtoReg_o      (m2r_o),
        .ALUres_o        (alu_o),
        .rddata_o        (rd_o),
        .WriteBackPath_o (wbp_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_memwb(input string tag, input logic e_rw, input logic e_m2r,
                               input logic [31:0] e_alu, input logic [31:0] e_rd,
                               input logic [4:0] e_wbp);
        check({tag, ".ctl"}, {25'd0, rw_o, m2r_o, wbp_o}, {25'd0, e_rw, e_m2r, e_wbp});
        check({tag, ".alu"}, alu_o, e_alu);
        check({tag, ".rd"}, rd_o, e_rd);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage; ack_k is the WAIT cycle in which ack
    // arrives, anything beyond M means the memory never answers.
    task automatic run_op(input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wbp,
                          input int ack_k, input logic [31:0] rd);
        logic        acc;
        logic        tmo;
        int          n_wait;
        logic [31:0] exp_rd;
        acc    = mr | mw;
        tmo    = (ack_k > M);
        n_wait = tmo ? M : ack_k;
        exp_rd = (acc && mr && !mw && !tmo) ? rd : 32'd0;
        mem_read = mr; mem_write = mw; reg_write = rw; mem_to_reg = m2r;
        alu_res = a; wr_data = wd; wb_path = wbp; ack = 1'b0;
        #1;
        check("stall_issue", {31'd0, stall}, {31'd0, acc});
        if (acc) begin
            for (int i = 1; i <= n_wait; i++) begin
                next_cycle();
                ack   = (i == ack_k);
                rdata = rd;
                #1;
                check("wait.req", {31'd0, req}, 32'd1);
                check("wait.stall", {31'd0, stall}, 32'd1);
                check("wait.addr", addr, a);
                check("wait.wdata", wdata, wd);
                check("wait.we", {31'd0, we}, {31'd0, mw});
                check_memwb("wait.bubble", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
            end
            next_cycle();
            ack = 1'b0;
            rdata = $urandom;
            if (tmo) err_model = 1'b1;
            #1;
            check("done.stall", {31'd0, stall}, 32'd0);
            check("done.req", {31'd0, req}, 32'd0);
            check_memwb("done.bubble", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        end
        next_cycle();
        check_memwb("result", rw, m2r, a, exp_rd, wbp);
        check("err", {31'd0, err}, {31'd0, err_model});
    endtask

    initial begin
        next_cycle();
        next_cycle();
        check_memwb("reset", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        check("reset.req_we", {30'd0, req, we}, 32'd0);
        check("reset.addr", addr, 32'd0);
        check("reset.wdata", wdata, 32'd0);
        check("reset.err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // ALU pass-through
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
        // Load 0x40, ack on third request cycle
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
        // Store, ack in first WAIT cycle
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h1234_5678, 5'd0, 1, 32'hFFFF_FFFF);
        // Timeout: memory never acks
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'hC0, 32'h0, 5'd9, 100, 32'hAAAA_5555);
        // Pipeline resumes, err sticky
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 32'h0, 5'd3, 0, 32'h0);
        // Read and write both set
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h90, 32'hCAFE_F00D, 5'd11, 2, 32'h5A5A_5A5A);

        // Reset in the second WAIT cycle, then a late ack
        mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; mem_to_reg = 1'b1;
        alu_res = 32'h100; wb_path = 5'd4;
        next_cycle();
        next_cycle();
        check("rst_mid.req_before", {31'd0, req}, 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mem_read = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0; alu_res = '0; wb_path = '0;
        err_model = 1'b0;
        #1;
        check("rst_mid.req", {31'd0, req}, 32'd0);
        check("rst_mid.stall", {31'd0, stall}, 32'd0);
        check("rst_mid.err", {31'd0, err}, 32'd0);
        check_memwb("rst_mid.out", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        next_cycle();
        ack = 1'b1; rdata = 32'h1111_2222;
        #1;
        check("late_ack.req", {31'd0, req}, 32'd0);
        check("late_ack.stall", {31'd0, stall}, 32'd0);
        next_cycle();
        ack = 1'b0;
        check_memwb("late_ack.out", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        check("late_ack.err", {31'd0, err}, 32'd0);

        // Randomized instruction mix, including occasional timeouts
        for (int t = 0; t < 60; t++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            run_op(kind == 2'd1 || kind == 2'd3, kind == 2'd2 || kind == 2'd3,
                   1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                   $urandom_range(1, M + 2), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
